// File: rtl/comp2_checker.sv
// comp2_checker
//   Sweeps all sixteen 2-bit {A,B} vectors into an external comparator and
//   checks its three result lines against the unsigned relation of A and B.
//   Each vector is held for SETTLE_CYC cycles. The comparator is sampled on
//   the following cycle.
//
// Parameters
//   SETTLE_CYC  settle cycles per vector before sampling (1..15)
//
// Ports
//   clk                     rising-edge clock
//   rst_n                   asynchronous active-low reset
//   start                   one-cycle sweep request (accepted in IDLE/DONE)
//   outa,outb,outc,outd     registered vector, A={outa,outb}, B={outc,outd}
//   inf1,inf2,inf3          comparator results A>B, A==B, A<B
//   busy                    sweep in progress
//   done                    sweep finished, held until next accepted start
//   pass                    done with zero mismatches
//   err_cnt                 mismatching vectors (saturates at 16)
//   first_fail              vector index {A,B} of the first mismatch
//
// Build option
//   COMP2_CHK_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep
//                              and the failing vector is left on the outputs.
module comp2_checker #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       outa,
  output logic       outb,
  output logic       outc,
  output logic       outd,
  input  logic       inf1,
  input  logic       inf2,
  input  logic       inf3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_fail
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  vec;
  logic [3:0]  settle_cnt;
  logic [4:0]  err;
  logic [3:0]  ff;

  logic        accept;
  logic        advance;
  logic        sample;
  logic        mismatch;
  logic [1:0]  a_val;
  logic [1:0]  b_val;
  logic [2:0]  expected;

  function automatic logic [4:0] sat_inc(input logic [4:0] e);
    return (e >= 5'd16) ? 5'd16 : e + 5'd1;
  endfunction

  // Expected pattern is always one-hot, so 000/111 or any multi-hot
  // response from the comparator fails the equality test.
  always_comb begin
    a_val    = vec[3:2];
    b_val    = vec[1:0];
    expected = {a_val > b_val, a_val == b_val, a_val < b_val};
    mismatch = ({inf1, inf2, inf3} != expected);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        sample = 1'b1;
`ifdef COMP2_CHK_STOP_ON_FAIL_EN
        if (mismatch || vec == 4'd15) begin
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = SETTLE;
        end
`else
        if (vec == 4'd15) begin
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = SETTLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Vector only moves on edges that enter SETTLE (accept or advance), so the
  // comparator sees a stable input through settle and sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 4'd0;
      settle_cnt <= 4'd0;
      err        <= 5'd0;
      ff         <= 4'd0;
    end else if (accept) begin
      vec        <= 4'd0;
      settle_cnt <= 4'd0;
      err        <= 5'd0;
      ff         <= 4'd0;
    end else begin
      if (state == SETTLE)
        settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
      if (advance)
        vec <= vec + 4'd1;
      if (sample && mismatch) begin
        err <= sat_inc(err);
        if (err == 5'd0) ff <= vec;
      end
    end
  end

  always_comb begin
    {outa, outb, outc, outd} = vec;
    busy       = (state == SETTLE) || (state == SAMPLE);
    done       = (state == DONE);
    pass       = (state == DONE) && (err == 5'd0);
    err_cnt    = err;
    first_fail = ff;
  end

endmodule

// File: tb/tb_comp2_checker.sv
// Testbench for comp2_checker: a behavioural comparator model with selectable
// faults drives the result lines; a reference model computes the expected
// sweep outcome, which is queued at start and checked when done rises.
module tb_comp2_checker;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       outa, outb, outc, outd;
  logic       inf1, inf2, inf3;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [3:0] first_fail;

  comp2_checker #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .outa(outa), .outb(outb), .outc(outc), .outd(outd),
    .inf1(inf1), .inf2(inf2), .inf3(inf3),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail(first_fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // comparator modes: 0 ideal, 1 inf2 stuck 0, 2 A/B swapped, 3 tied 111,
  // 4 random corruption table
  int         mode = 0;
  logic [2:0] rnd_tab [16];

  function automatic logic [2:0] ideal(input int v);
    int a, b;
    a = v / 4;
    b = v % 4;
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic logic [2:0] cmp_resp(input int md, input int v);
    case (md)
      1:       return ideal(v) & 3'b101;
      2:       return ideal((v % 4) * 4 + v / 4);
      3:       return 3'b111;
      4:       return rnd_tab[v];
      default: return ideal(v);
    endcase
  endfunction

  always_comb {inf1, inf2, inf3} = cmp_resp(mode, int'({outa, outb, outc, outd}));

  typedef struct {
    int err;
    int ff;
    int pss;
    int last;
    int lat;
  } exp_t;

  exp_t q[$];
  int   start_cyc = 0;
  int   n_done = 0;
  int   total = 0;
  int   bad = 0;

  function automatic exp_t ref_sweep(input int md);
    exp_t e;
    int   n;
    e.err  = 0;
    e.ff   = 0;
    e.last = 15;
    n      = 16;
    for (int v = 0; v < 16; v++) begin
      if (cmp_resp(md, v) != ideal(v)) begin
        if (e.err == 0) e.ff = v;
        if (e.err < 16) e.err++;
`ifdef COMP2_CHK_STOP_ON_FAIL_EN
        e.last = v;
        n      = v + 1;
        break;
`endif
      end
    end
    e.pss = (e.err == 0) ? 1 : 0;
    e.lat = n * (S + 1);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // monitor: pops one expectation per rising edge of done
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !prev_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("err_cnt",    int'(err_cnt),    e.err);
          chk("first_fail", int'(first_fail), e.ff);
          chk("pass",       int'(pass),       e.pss);
          chk("final_vec",  int'({outa, outb, outc, outd}), e.last);
          chk("busy_done",  int'(busy),       0);
          chk("latency",    cyc - start_cyc,  e.lat);
        end
        n_done++;
      end
      prev_done = done;
    end
  end

  task automatic run_sweep(input int md, input int extra_at);
    exp_t e;
    int   nd0;
    int   k;
    mode = md;
    if (md == 4)
      for (int i = 0; i < 16; i++)
        rnd_tab[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : ideal(i);
    e = ref_sweep(md);
    @(negedge clk);
    start = 1'b1;
    q.push_back(e);
    nd0 = n_done;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", int'(busy), 1);
    chk("done_after_start", int'(done), 0);
    k = 0;
    while (n_done == nd0 && k < 400) begin
      @(negedge clk);
      k++;
      start = (extra_at > 0 && k == extra_at) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    if (n_done == nd0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end else begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      chk("done_hold", int'(done), 1);
      chk("vec_hold",  int'({outa, outb, outc, outd}), e.last);
      chk("err_hold",  int'(err_cnt), e.err);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_pass"},  int'(pass), 0);
    chk({tag, "_err"},   int'(err_cnt), 0);
    chk({tag, "_ff"},    int'(first_fail), 0);
    chk({tag, "_vec"},   int'({outa, outb, outc, outd}), 0);
  endtask

  initial begin
    start = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(0, 0);   // ideal
    run_sweep(1, 0);   // inf2 stuck low
    run_sweep(2, 0);   // A/B swapped
    run_sweep(3, 0);   // all ones
    run_sweep(0, 10);  // second start mid-sweep ignored

    // mid-sweep reset with errors already accumulating
    mode = 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_before_rst", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midrst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 0);

    for (int i = 0; i < 8; i++)
      run_sweep($urandom_range(0, 4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comp2_checker.md
COMP2_CHECKER -- requirements
Module: comp2_checker

Interface
REQ-001 SETTLE_CYC, 2, cycles between applying a vector and sampling the comparator results (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset; the block has one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  one-cycle request to run a full sweep.
REQ-005 outa, outb, outc, outd  output  1 each  vector bits driven to the comparator under test; A={outa,outb}, B={outc,outd}.
REQ-006 inf1, inf2, inf3  input  1 each  comparator results: A>B, A==B, A<B respectively.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  high once a sweep has completed; held until the next accepted start.
REQ-009 pass  output  1  high when done=1 and err_cnt==0.
REQ-010 err_cnt  output  5  count of mismatching vectors in the current or last sweep.
REQ-011 first_fail  output  4  vector index {A,B} of the first mismatch; valid when err_cnt!=0.

Function
REQ-012 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL move to SETTLE with vector=0, err_cnt=0, done=0 and busy=1.
REQ-014 start SHALL be ignored while in SETTLE or SAMPLE.
REQ-015 SETTLE SHALL hold the vector for exactly SETTLE_CYC cycles and then enter SAMPLE.
REQ-016 SAMPLE SHALL last one cycle: expected = {A>B, A==B, A<B}, computed unsigned on 2-bit A and B, compared with {inf1,inf2,inf3}.
REQ-017 A mismatch SHALL increment err_cnt, and on the first mismatch of a sweep SHALL load first_fail with the vector.
REQ-018 After SAMPLE, vector==15 SHALL go to DONE; otherwise vector SHALL increment by 1 and the FSM SHALL go to SETTLE.
REQ-019 A full sweep SHALL take exactly 16*(SETTLE_CYC+1) cycles from the start-accept edge to done rising.
REQ-020 In DONE: busy=0, done=1, and pass = (err_cnt==0); outputs SHALL hold until the next accepted start.
REQ-021 The vector outputs SHALL be registered and SHALL change only on the edge that enters SETTLE.
REQ-022 err_cnt SHALL saturate at 16 and never wrap.
REQ-023 Any result pattern that is not one-hot, including 000 and 111, SHALL count as a mismatch.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, with vector outputs=0, busy=0, done=0, pass=0, err_cnt=0 and first_fail=0.
REQ-025 Reset asserted mid-sweep SHALL abort the sweep with no residual state.
REQ-026 Operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With COMP2_CHK_STOP_ON_FAIL_EN defined, the first mismatch SHALL end the sweep: the FSM enters DONE directly from SAMPLE with err_cnt=1, pass=0 and the vector held at the failing value.
REQ-028 Without COMP2_CHK_STOP_ON_FAIL_EN, all 16 vectors SHALL always be applied.

Verification
REQ-029 Ideal comparator model with SETTLE_CYC=2: one start pulse -> done after 48 cycles, pass=1, err_cnt=0.
REQ-030 Model with inf2 stuck at 0: sweep completes, err_cnt=4 (vectors 0, 5, 10, 15), first_fail=0, pass=0.
REQ-031 Model with A/B swapped, macro defined: DONE after vector 1 (A=0, B=1), err_cnt=1, first_fail=1, outputs hold vector 1.
REQ-032 Ideal model: rst_n pulsed low at cycle 20 of a sweep -> all outputs 0 immediately; a new start -> full 48-cycle pass.
REQ-033 start pulsed again at cycle 10 of a sweep -> ignored; done still rises at cycle 48.
REQ-034 inf1..inf3 tied to 111: err_cnt=16 (saturated), pass=0.
